pll_reconfig_seq: RTL and testbench
===================================

Name: pll_reconfig_seq

Overview:
- Upstream sequencer for the reconfigurable NMR system PLL (Cyclone V, 50 MHz refclk, 412.8 MHz VCO, fractional M).
- Takes a host request for new M, K (fractional), and C0 counter settings and writes them over Avalon-MM to the PLL reconfiguration core, which drives the PLL's 64-bit reconfig bus.
- After writing, it starts the reconfiguration, polls for completion, then qualifies PLL lock before reporting done or error.
- Lets software retune the NMR clock (for example, 68.8 MHz) without a rebuild.

Parameters:
- C_SEL, 0: C counter index written into the C-register select field (bits [22:18]).
- POLL_LIMIT, 1023: maximum status reads before error.
- LOCK_STABLE, 16: consecutive synchronised locked-high cycles required.
- LOCK_TIMEOUT, 65535: cycles allowed for lock. Used only with the optional feature.

Ports:
- clk  in  1  reference-domain clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; ignored unless idle
- m_hi  in  8  M counter high count
- m_lo  in  8  M counter low count
- m_odd  in  1  M odd-divide duty enable
- k_frac  in  32  fractional M value
- c_hi  in  8  C counter high count
- c_lo  in  8  C counter low count
- c_odd  in  1  C odd-divide duty enable
- busy  out  1  high from accepted start until done/error
- done  out  1  one-cycle pulse on success
- error  out  1  one-cycle pulse on poll or lock failure
- err_code  out  2  0 none, 1 poll limit, 2 lock timeout; held until next start
- mgmt_address  out  6  Avalon-MM address
- mgmt_read  out  1  Avalon read
- mgmt_write  out  1  Avalon write
- mgmt_writedata  out  32  Avalon write data
- mgmt_readdata  in  32  Avalon read data
- mgmt_waitrequest  in  1  Avalon waitrequest
- pll_locked  in  1  PLL locked (asynchronous to clk)

Behaviour:
- Reset: all outputs 0. FSM returns to IDLE and counters clear. Reset mid-transaction drops mgmt_read/mgmt_write in the next cycle; no bus-completion wait.
- Input capture: on start in IDLE, m_*, k_frac, and c_* are registered. Later input changes have no effect on the sequence in progress.
- pll_locked passes through a 2-flop synchroniser before use.
- Avalon rule: address, data, and read/write are held stable while waitrequest=1. A transfer completes in the first cycle with waitrequest=0. On a read, mgmt_readdata is sampled in that same cycle. At most one command is asserted at a time, and the command deasserts for 1 cycle between transfers.
- FSM sequence:
  - IDLE: busy=0. On start, go to WR_MODE and set busy=1.
  - WR_MODE: address 0, data 1 (polling mode).
  - WR_M: address 4, data {14'b0, m_odd, 1'b0, m_hi, m_lo}.
  - WR_K: address 7, data k_frac.
  - WR_C: address 5, data {9'b0, C_SEL[4:0], c_odd, 1'b0, c_hi, c_lo}.
  - WR_START: address 2, data 1.
  - RD_STAT: address 1, read. If bit0=1, go to WAIT_LOCK. Otherwise increment the poll counter and repeat. When the counter reaches POLL_LIMIT with bit0 still 0, go to ERR with code 1.
  - WAIT_LOCK: count consecutive synchronised locked-high cycles. Any low sample resets the count. At LOCK_STABLE, go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
  - ERR: error=1 for one cycle, busy=0, return to IDLE.
- start while busy: ignored, with no queueing.
- start in the same cycle as rst: rst wins.
- Latency (waitrequest always 0, status ready on the first read, lock already stable): 6 bus transfers, 5 idle gaps, plus LOCK_STABLE cycles to done.

Optional Feature:
- Macro: PLL_RECFG_LOCK_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT_LOCK. When it reaches LOCK_TIMEOUT without qualified lock, go to ERR with err_code=2. The counter clears on entry to WAIT_LOCK.
- Undefined: WAIT_LOCK waits indefinitely, err_code never takes the value 2, and no timeout counter is synthesised.

Test Plan:
- Nominal: m_hi=4, m_lo=4, k_frac=0x4189374C, c_hi=3, c_lo=3, C_SEL=0, waitrequest=0, status bit0=1, locked=1.
  - Required writes, in order: (0,0x1), (4,0x00000404), (7,0x4189374C), (5,0x00000303), (2,0x1).
  - Then one read of address 1, then done 16 cycles later with err_code=0.
- Waitrequest stall: hold waitrequest=1 for 5 cycles on every transfer. Address and data must stay stable, with exactly one accepted transfer each, and the same order as the nominal case.
- Poll limit: with POLL_LIMIT=4 and status bit0 always 0, exactly 4 reads occur, then error pulses with err_code=1 and busy falls.
- Lock glitch: drop locked for 1 cycle after 10 high cycles. done occurs only after 16 new consecutive high cycles.
- Timeout (macro defined, LOCK_TIMEOUT=100, locked=0): error with err_code=2 100 cycles after entering WAIT_LOCK. With the macro undefined, busy stays 1 indefinitely.
- Reset and start handling:
  - Assert rst during WR_K: all outputs are 0 on the next cycle.
  - A second start pulse while busy produces no additional bus transfers.

Source files
------------

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: writes M/K/C settings to the PLL reconfig core, polls completion, qualifies lock; PLL_RECFG_LOCK_TIMEOUT_EN adds a lock timeout
module pll_reconfig_seq #(
   parameter int C_SEL        = 0,
   parameter int POLL_LIMIT   = 1023,
   parameter int LOCK_STABLE  = 16,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  m_hi,
   input  logic [7:0]  m_lo,
   input  logic        m_odd,
   input  logic [31:0] k_frac,
   input  logic [7:0]  c_hi,
   input  logic [7:0]  c_lo,
   input  logic        c_odd,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [5:0]  mgmt_address,
   output logic        mgmt_read,
   output logic        mgmt_write,
   output logic [31:0] mgmt_writedata,
   input  logic [31:0] mgmt_readdata,
   input  logic        mgmt_waitrequest,
   input  logic        pll_locked
);
   typedef enum logic [3:0] {IDLE, WR_MODE, WR_M, WR_K, WR_C, WR_START, RD_STAT, WAIT_LOCK, DONE, ERR} state_t;
   localparam int PW = $clog2(POLL_LIMIT + 1);
   localparam int LW = $clog2(LOCK_STABLE + 1);
   state_t state;
   logic [17:0] m_word, c_word;
   logic [31:0] k_r;
   logic [PW-1:0] poll_cnt;
   logic [LW-1:0] lock_cnt;
   logic [1:0] lock_sync;
   logic [5:0] addr_n;
   logic [31:0] data_n;
   logic cmd, unused_rd;
   assign cmd = mgmt_read | mgmt_write;
   assign unused_rd = ^mgmt_readdata[31:1];
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   logic [TW-1:0] to_cnt;
`else
   logic [31:0] unused_to;
   assign unused_to = 32'(LOCK_TIMEOUT);
`endif
   always_comb begin
      addr_n = 6'd0;
      data_n = 32'd0;
      case (state)
         WR_MODE:  data_n = 32'd1;
         WR_M:     begin addr_n = 6'd4; data_n = {14'd0, m_word}; end
         WR_K:     begin addr_n = 6'd7; data_n = k_r; end
         WR_C:     begin addr_n = 6'd5; data_n = {9'd0, 5'(C_SEL), c_word}; end
         WR_START: begin addr_n = 6'd2; data_n = 32'd1; end
         RD_STAT:  addr_n = 6'd1;
         default:  ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         {busy, done, error, err_code} <= '0;
         {mgmt_address, mgmt_read, mgmt_write, mgmt_writedata} <= '0;
         {m_word, c_word, k_r} <= '0;
         poll_cnt <= '0;
         lock_cnt <= '0;
         lock_sync <= '0;
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
         to_cnt <= '0;
`endif
      end else begin
         lock_sync <= {lock_sync[0], pll_locked};
         done <= 1'b0;
         error <= 1'b0;
         case (state)
            IDLE: if (start) begin
               m_word <= {m_odd, 1'b0, m_hi, m_lo};
               c_word <= {c_odd, 1'b0, c_hi, c_lo};
               k_r <= k_frac;
               busy <= 1'b1;
               err_code <= 2'd0;
               poll_cnt <= '0;
               mgmt_address <= 6'd0;
               mgmt_writedata <= 32'd1;
               mgmt_write <= 1'b1;
               state <= WR_MODE;
            end
            WR_MODE, WR_M, WR_K, WR_C, WR_START, RD_STAT: begin
               if (!cmd) begin
                  mgmt_address <= addr_n;
                  mgmt_writedata <= data_n;
                  mgmt_write <= state != RD_STAT;
                  mgmt_read <= state == RD_STAT;
               end else if (!mgmt_waitrequest) begin
                  mgmt_write <= 1'b0;
                  mgmt_read <= 1'b0;
                  // write states are consecutive in the enum, so +1 walks the write order
                  if (state != RD_STAT) state <= state_t'(state + 4'd1);
                  else if (mgmt_readdata[0]) begin
                     state <= WAIT_LOCK;
                     lock_cnt <= '0;
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
                     to_cnt <= '0;
`endif
                  end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
                     state <= ERR;
                     error <= 1'b1;
                     busy <= 1'b0;
                     err_code <= 2'd1;
                  end else poll_cnt <= poll_cnt + PW'(1);
               end
            end
            WAIT_LOCK: begin
               lock_cnt <= lock_sync[1] ? lock_cnt + LW'(1) : '0;
               if (lock_sync[1] && lock_cnt == LW'(LOCK_STABLE - 1)) begin
                  state <= DONE;
                  done <= 1'b1;
                  busy <= 1'b0;
               end
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
               else if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                  state <= ERR;
                  error <= 1'b1;
                  busy <= 1'b0;
                  err_code <= 2'd2;
               end
               to_cnt <= to_cnt + TW'(1);
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb_pll_reconfig_seq: directed bench for pll_reconfig_seq with an Avalon slave model and transfer log
module tb_pll_reconfig_seq;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [7:0] m_hi = 8'd4, m_lo = 8'd4, c_hi = 8'd3, c_lo = 8'd3;
   logic m_odd = 1'b0, c_odd = 1'b0;
   logic [31:0] k_frac = 32'h4189374C;
   logic busy, done, error;
   logic [1:0] err_code;
   logic [5:0] mgmt_address;
   logic mgmt_read, mgmt_write;
   logic [31:0] mgmt_writedata, mgmt_readdata;
   logic mgmt_waitrequest = 1'b0, pll_locked = 1'b1, stat_bit = 1'b1, stall = 1'b0;
   int checks = 0, failures = 0;
   int cyc = 0, n_xfer = 0, n_done = 0, n_err = 0, done_cyc = 0, err_cyc = 0, stab_err = 0, ws = 0;
   logic [5:0] q_addr [128];
   logic [31:0] q_data [128];
   logic q_rd [128];
   int q_cyc [128];
   logic pend = 1'b0, just_done = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
   logic [5:0] p_addr = '0;
   logic [31:0] p_data = '0;
   logic [5:0] exp_addr [6] = '{6'd0, 6'd4, 6'd7, 6'd5, 6'd2, 6'd1};
   logic [31:0] exp_data [6] = '{32'h1, 32'h404, 32'h4189374C, 32'h303, 32'h1, 32'h0};
   logic exp_rd [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   pll_reconfig_seq #(.C_SEL(0), .POLL_LIMIT(4), .LOCK_STABLE(16), .LOCK_TIMEOUT(100)) dut (
      .clk(clk), .rst(rst), .start(start), .m_hi(m_hi), .m_lo(m_lo), .m_odd(m_odd), .k_frac(k_frac),
      .c_hi(c_hi), .c_lo(c_lo), .c_odd(c_odd), .busy(busy), .done(done), .error(error), .err_code(err_code),
      .mgmt_address(mgmt_address), .mgmt_read(mgmt_read), .mgmt_write(mgmt_write),
      .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
      .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
   );

   assign mgmt_readdata = {31'd0, stat_bit};
   always #5 clk = ~clk;

   // slave model: optional 5-cycle stall per transfer, logs accepted transfers, checks bus protocol
   always @(negedge clk) begin
      cyc++;
      if (pend && (mgmt_address !== p_addr || mgmt_writedata !== p_data || mgmt_read !== p_rd || mgmt_write !== p_wr)) stab_err++;
      if ((mgmt_read && mgmt_write) || (just_done && (mgmt_read || mgmt_write))) stab_err++;
      just_done = 1'b0;
      if (mgmt_read || mgmt_write) begin
         if (stall && ws < 5) begin
            ws++;
            mgmt_waitrequest = 1'b1;
         end else begin
            if (n_xfer < 128) begin
               q_addr[n_xfer] = mgmt_address;
               q_data[n_xfer] = mgmt_read ? 32'd0 : mgmt_writedata;
               q_rd[n_xfer] = mgmt_read;
               q_cyc[n_xfer] = cyc;
            end
            n_xfer++;
            ws = 0;
            mgmt_waitrequest = 1'b0;
            just_done = 1'b1;
         end
      end else begin
         ws = 0;
         mgmt_waitrequest = stall;
      end
      pend = (mgmt_read || mgmt_write) && mgmt_waitrequest;
      {p_addr, p_data, p_rd, p_wr} = {mgmt_address, mgmt_writedata, mgmt_read, mgmt_write};
      if (done) begin n_done++; done_cyc = cyc; end
      if (error) begin n_err++; err_cyc = cyc; end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_end(input int base, input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (n_done + n_err > base) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic wait_read(input int bx, output bit ok);
      for (int i = 0; i < 100 && n_xfer - bx < 6; i++) tick();
      ok = n_xfer - bx >= 6;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({busy, done, error, err_code, mgmt_address, mgmt_read, mgmt_write, mgmt_writedata} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b done=%b err=%b code=%0d addr=%0d rd=%b wr=%b wd=%h want all 0",
                  busy, done, error, err_code, mgmt_address, mgmt_read, mgmt_write, mgmt_writedata);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b want 0", busy); end
   endtask

   task automatic test_nominal;
      int bx = n_xfer, be = n_done + n_err, bd = n_done, bs = stab_err;
      bit ok;
      pulse_start();
      {m_hi, m_lo, k_frac, c_hi, c_lo, m_odd, c_odd} = {8'hFF, 8'hEE, 32'h0, 8'hDD, 8'hCC, 1'b1, 1'b1};
      wait_end(be, 200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL nominal_timeout no done/error within 200 cycles"); end
      checks++;
      if (n_xfer - bx !== 6) begin failures++; $display("FAIL nominal_xfer_count got %0d want 6", n_xfer - bx); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({q_rd[bx+i], q_addr[bx+i], q_data[bx+i]} !== {exp_rd[i], exp_addr[i], exp_data[i]}) begin
            failures++;
            $display("FAIL nominal_xfer%0d got rd=%b addr=%0d data=%h want rd=%b addr=%0d data=%h",
                     i, q_rd[bx+i], q_addr[bx+i], q_data[bx+i], exp_rd[i], exp_addr[i], exp_data[i]);
         end
      end
      checks++;
      if (n_done - bd !== 1 || done_cyc - q_cyc[bx+5] !== 17) begin
         failures++;
         $display("FAIL nominal_done_latency got pulses=%0d gap=%0d want pulses=1 gap=17", n_done - bd, done_cyc - q_cyc[bx+5]);
      end
      checks++;
      if ({busy, err_code} !== 3'b000) begin failures++; $display("FAIL nominal_end busy=%b code=%0d want 0 0", busy, err_code); end
      checks++;
      if (stab_err !== bs) begin failures++; $display("FAIL nominal_protocol violations=%0d want 0", stab_err - bs); end
      {m_hi, m_lo, k_frac, c_hi, c_lo, m_odd, c_odd} = {8'd4, 8'd4, 32'h4189374C, 8'd3, 8'd3, 1'b0, 1'b0};
   endtask

   task automatic test_start_busy;
      int bx = n_xfer, be = n_done + n_err, bd = n_done;
      bit ok;
      pulse_start();
      tick();
      pulse_start();
      repeat (6) tick();
      pulse_start();
      wait_end(be, 200, ok);
      repeat (6) tick();
      checks++;
      if (!ok || n_xfer - bx !== 6 || n_done - bd !== 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL start_while_busy got ok=%b xfers=%0d dones=%0d busy=%b want 1 6 1 0", ok, n_xfer - bx, n_done - bd, busy);
      end
   endtask

   task automatic test_stall;
      int bx = n_xfer, be = n_done + n_err, bs = stab_err;
      bit ok;
      stall = 1'b1;
      tick();
      pulse_start();
      wait_end(be, 400, ok);
      stall = 1'b0;
      checks++;
      if (!ok || n_xfer - bx !== 6) begin failures++; $display("FAIL stall_count ok=%b got %0d want 6", ok, n_xfer - bx); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({q_rd[bx+i], q_addr[bx+i], q_data[bx+i]} !== {exp_rd[i], exp_addr[i], exp_data[i]}) begin
            failures++;
            $display("FAIL stall_xfer%0d got rd=%b addr=%0d data=%h want rd=%b addr=%0d data=%h",
                     i, q_rd[bx+i], q_addr[bx+i], q_data[bx+i], exp_rd[i], exp_addr[i], exp_data[i]);
         end
      end
      checks++;
      if (q_cyc[bx+1] - q_cyc[bx] !== 7) begin failures++; $display("FAIL stall_spacing got %0d want 7", q_cyc[bx+1] - q_cyc[bx]); end
      checks++;
      if (stab_err !== bs) begin failures++; $display("FAIL stall_stable violations=%0d want 0", stab_err - bs); end
   endtask

   task automatic test_poll_limit;
      int bx = n_xfer, be = n_done + n_err, bd = n_done, br = n_err;
      bit ok;
      stat_bit = 1'b0;
      pulse_start();
      wait_end(be, 300, ok);
      checks++;
      if (!ok || n_xfer - bx !== 9 || !q_rd[bx+8] || q_addr[bx+8] !== 6'd1 || q_rd[bx+4]) begin
         failures++;
         $display("FAIL poll_reads ok=%b xfers=%0d want 9 (5 writes + 4 reads)", ok, n_xfer - bx);
      end
      checks++;
      if (n_err - br !== 1 || n_done - bd !== 0 || err_code !== 2'd1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL poll_error errs=%0d dones=%0d code=%0d busy=%b want 1 0 1 0", n_err - br, n_done - bd, err_code, busy);
      end
      repeat (5) tick();
      checks++;
      if (err_code !== 2'd1) begin failures++; $display("FAIL poll_code_held got %0d want 1", err_code); end
      stat_bit = 1'b1;
   endtask

   task automatic test_lock_glitch;
      int bx = n_xfer, be = n_done + n_err, bd = n_done;
      bit ok;
      pulse_start();
      checks++;
      if (err_code !== 2'd0) begin failures++; $display("FAIL start_clears_code got %0d want 0", err_code); end
      wait_read(bx, ok);
      repeat (9) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      wait_end(be, 200, ok);
      checks++;
      if (!ok || n_done - bd !== 1 || done_cyc - q_cyc[bx+5] !== 29) begin
         failures++;
         $display("FAIL lock_glitch ok=%b dones=%0d gap=%0d want 1 1 29", ok, n_done - bd, done_cyc - q_cyc[bx+5]);
      end
   endtask

   task automatic test_lock_wait;
      int bx = n_xfer, be = n_done + n_err, bd = n_done, br = n_err;
      bit ok;
      pll_locked = 1'b0;
      pulse_start();
      wait_read(bx, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL lock_wait_read no status read within 100 cycles"); end
`ifdef PLL_RECFG_LOCK_TIMEOUT_EN
      wait_end(be, 300, ok);
      checks++;
      if (!ok || n_err - br !== 1 || err_cyc - q_cyc[bx+5] !== 101 || err_code !== 2'd2 || busy !== 1'b0) begin
         failures++;
         $display("FAIL lock_timeout ok=%b errs=%0d gap=%0d code=%0d busy=%b want 1 1 101 2 0",
                  ok, n_err - br, err_cyc - q_cyc[bx+5], err_code, busy);
      end
      pll_locked = 1'b1;
`else
      repeat (300) tick();
      checks++;
      if (busy !== 1'b1 || n_err - br !== 0 || n_done - bd !== 0) begin
         failures++;
         $display("FAIL lock_wait_forever busy=%b errs=%0d dones=%0d want 1 0 0", busy, n_err - br, n_done - bd);
      end
      pll_locked = 1'b1;
      wait_end(be, 100, ok);
      checks++;
      if (!ok || n_done - bd !== 1 || err_code !== 2'd0) begin
         failures++;
         $display("FAIL lock_wait_recover ok=%b dones=%0d code=%0d want 1 1 0", ok, n_done - bd, err_code);
      end
`endif
      repeat (3) tick();
   endtask

   task automatic test_reset_mid;
      int bx;
      pulse_start();
      for (int i = 0; i < 50 && !(mgmt_write && mgmt_address == 6'd7); i++) tick();
      checks++;
      if (!(mgmt_write && mgmt_address == 6'd7)) begin failures++; $display("FAIL reset_mid_reach never saw WR_K write"); end
      rst = 1'b1;
      tick();
      checks++;
      if ({busy, done, error, err_code, mgmt_address, mgmt_read, mgmt_write, mgmt_writedata} !== '0) begin
         failures++;
         $display("FAIL reset_mid_outputs busy=%b rd=%b wr=%b addr=%0d wd=%h want all 0",
                  busy, mgmt_read, mgmt_write, mgmt_address, mgmt_writedata);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      rst = 1'b0;
      bx = n_xfer;
      repeat (5) tick();
      checks++;
      if (busy !== 1'b0 || n_xfer !== bx) begin
         failures++;
         $display("FAIL start_with_rst busy=%b xfers=%0d want 0 0", busy, n_xfer - bx);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_start_busy();
      test_stall();
      test_poll_limit();
      test_lock_glitch();
      test_lock_wait();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
